output_holdoff: RTL and testbench

//   Output-side counterpart of the input debouncer: conditions a logic-level

---
 rtl/output_holdoff.sv | 150 +++++++++++++++
 tb/tb_output_holdoff.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/output_holdoff.sv
`default_nettype none
// ============================================================================
// Module      : output_holdoff
// Description : Conditions an output request before the pin driver: minimum
//               high/low dwell, pulse stretching, one pending edge per dwell
//               and an optional on-time watchdog that latches a fault.
// Revision    : 1.0 - initial release
// ============================================================================
module output_holdoff #(
    parameter int MIN_HIGH = 16,
    parameter int MIN_LOW  = 16,
    parameter int MAX_HIGH = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic fault_clr,
    output logic dout,
    output logic busy,
    output logic fault
);

    localparam int c_HC_W   = $clog2(MIN_HIGH + 1);
    localparam int c_LC_W   = $clog2(MIN_LOW + 1);
    localparam bit c_WD_ON  = (MAX_HIGH != 0);
    localparam int c_WD_W   = c_WD_ON ? $clog2(MAX_HIGH + 1) : 1;

    localparam logic [c_HC_W-1:0] c_HC_LOAD = c_HC_W'(MIN_HIGH - 1);
    localparam logic [c_LC_W-1:0] c_LC_LOAD = c_LC_W'(MIN_LOW - 1);
    localparam logic [c_WD_W-1:0] c_WD_MAX  = c_WD_W'(MAX_HIGH);
    localparam logic [c_WD_W-1:0] c_WD_ONE  = c_WD_W'(1);

    localparam logic [2:0] c_S_LOW       = 3'd0;
    localparam logic [2:0] c_S_HOLD_HIGH = 3'd1;
    localparam logic [2:0] c_S_HIGH      = 3'd2;
    localparam logic [2:0] c_S_HOLD_LOW  = 3'd3;
    localparam logic [2:0] c_S_FAULT     = 3'd4;

    generate
        if (MIN_HIGH < 1) begin : g_chk_min_high
            $error("output_holdoff: MIN_HIGH must be >= 1");
        end
        if (MIN_LOW < 1) begin : g_chk_min_low
            $error("output_holdoff: MIN_LOW must be >= 1");
        end
        if (MAX_HIGH != 0 && MAX_HIGH <= MIN_HIGH) begin : g_chk_max_high
            $error("output_holdoff: MAX_HIGH must be 0 or greater than MIN_HIGH");
        end
    endgenerate

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic              r_din_q;
    logic              r_pend;
    logic [c_HC_W-1:0] r_hcnt;
    logic [c_LC_W-1:0] r_lcnt;
    logic [c_WD_W-1:0] r_wdog;
    logic              r_dout;
    logic              r_busy;
    logic              r_fault;

    logic w_wd_trip;
    logic w_pend_set;
    logic w_leave;
    logic w_hi_nxt;
    logic w_was_low;

    assign w_wd_trip  = c_WD_ON && (r_wdog == c_WD_MAX);
    assign w_pend_set = ((r_state == c_S_HOLD_HIGH) &&  r_din_q && !din) ||
                        ((r_state == c_S_HOLD_LOW)  && !r_din_q &&  din);
    assign w_leave    = (w_state_nxt != r_state);
    assign w_hi_nxt   = (w_state_nxt == c_S_HOLD_HIGH) || (w_state_nxt == c_S_HIGH);
    assign w_was_low  = (r_state == c_S_LOW) || (r_state == c_S_HOLD_LOW);

    // Watchdog is checked first so it wins over hold expiry and din.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_LOW: begin
                if (din) w_state_nxt = c_S_HOLD_HIGH;
            end
            c_S_HOLD_HIGH: begin
                if (w_wd_trip)
                    w_state_nxt = c_S_FAULT;
                else if (r_hcnt == '0)
                    w_state_nxt = (!din || r_pend) ? c_S_HOLD_LOW : c_S_HIGH;
            end
            c_S_HIGH: begin
                if (w_wd_trip)
                    w_state_nxt = c_S_FAULT;
                else if (!din)
                    w_state_nxt = c_S_HOLD_LOW;
            end
            c_S_HOLD_LOW: begin
                if (r_lcnt == '0)
                    w_state_nxt = (din || r_pend) ? c_S_HOLD_HIGH : c_S_LOW;
            end
            c_S_FAULT: begin
                if (fault_clr && !din) w_state_nxt = c_S_HOLD_LOW;
            end
            default: w_state_nxt = c_S_LOW;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_LOW;
            r_din_q <= 1'b0;
            r_pend  <= 1'b0;
            r_hcnt  <= '0;
            r_lcnt  <= '0;
            r_wdog  <= '0;
            r_dout  <= 1'b0;
            r_busy  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_din_q <= din;
            r_pend  <= w_leave ? 1'b0 : (r_pend | w_pend_set);

            if (w_leave && (w_state_nxt == c_S_HOLD_HIGH))
                r_hcnt <= c_HC_LOAD;
            else if ((r_state == c_S_HOLD_HIGH) && (r_hcnt != '0))
                r_hcnt <= r_hcnt - 1'b1;

            if (w_leave && (w_state_nxt == c_S_HOLD_LOW))
                r_lcnt <= c_LC_LOAD;
            else if ((r_state == c_S_HOLD_LOW) && (r_lcnt != '0))
                r_lcnt <= r_lcnt - 1'b1;

            // On-time counter: first high cycle counts as 1, saturates at limit.
            if (!w_hi_nxt)
                r_wdog <= '0;
            else if (w_was_low)
                r_wdog <= c_WD_ONE;
            else if (c_WD_ON && (r_wdog != c_WD_MAX))
                r_wdog <= r_wdog + 1'b1;

            r_dout  <= w_hi_nxt;
            r_busy  <= (w_state_nxt == c_S_HOLD_HIGH) || (w_state_nxt == c_S_HOLD_LOW);
            r_fault <= (w_state_nxt == c_S_FAULT);
        end
    end

    assign dout  = r_dout;
    assign busy  = r_busy;
    assign fault = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_output_holdoff.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_holdoff
// Description : Directed bench for output_holdoff with three parameter sets
//               (no watchdog, MAX_HIGH=100, MAX_HIGH=MIN_HIGH+1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_holdoff;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic din_a = 1'b0, clr_a = 1'b0, dout_a, busy_a, fault_a;
    logic din_w = 1'b0, clr_w = 1'b0, dout_w, busy_w, fault_w;
    logic din_s = 1'b0, clr_s = 1'b0, dout_s, busy_s, fault_s;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    output_holdoff #(.MIN_HIGH(16), .MIN_LOW(16), .MAX_HIGH(0)) dut_a (
        .clk(clk), .rst(rst), .din(din_a), .fault_clr(clr_a),
        .dout(dout_a), .busy(busy_a), .fault(fault_a)
    );

    output_holdoff #(.MIN_HIGH(16), .MIN_LOW(16), .MAX_HIGH(100)) dut_w (
        .clk(clk), .rst(rst), .din(din_w), .fault_clr(clr_w),
        .dout(dout_w), .busy(busy_w), .fault(fault_w)
    );

    output_holdoff #(.MIN_HIGH(16), .MIN_LOW(16), .MAX_HIGH(17)) dut_s (
        .clk(clk), .rst(rst), .din(din_s), .fault_clr(clr_s),
        .dout(dout_s), .busy(busy_s), .fault(fault_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // kind: 0 = dout, 1 = busy, 2 = fault
    function automatic logic probe(input int sel, input int kind);
        logic [2:0] v;
        case (sel)
            0:       v = {dout_a, busy_a, fault_a};
            1:       v = {dout_w, busy_w, fault_w};
            default: v = {dout_s, busy_s, fault_s};
        endcase
        return v[2-kind];
    endfunction

    // Counts consecutive samples (current one included) at level lvl, bounded.
    task automatic run_len(input int sel, input int kind, input logic lvl, output int n);
        n = 0;
        while ((probe(sel, kind) == lvl) && (n < 300)) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int   n;
        int   run, nruns, minr, maxr;
        logic prev;
        bit   first;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout_a", int'(dout_a), 0);
        check("rst_busy_a", int'(busy_a), 0);
        check("rst_fault_a", int'(fault_a), 0);
        check("rst_dout_w", int'(dout_w), 0);
        check("rst_fault_s", int'(fault_s), 0);
        rst = 1'b0;
        tick();

        // 1-cycle pulse from LOW -> 16-cycle high, then 16 cycles busy at 0
        din_a = 1'b1;
        tick();
        check("pulse_rise_dout", int'(dout_a), 1);
        check("pulse_rise_busy", int'(busy_a), 1);
        din_a = 1'b0;
        run_len(0, 0, 1'b1, n);
        check("pulse_high_len", n, 16);
        check("pulse_holdlow_busy", int'(busy_a), 1);
        run_len(0, 1, 1'b1, n);
        check("pulse_holdlow_len", n, 16);
        check("pulse_idle_busy", int'(busy_a), 0);
        check("pulse_idle_dout", int'(dout_a), 0);

        // Pulse arriving mid HOLD_LOW is remembered once
        din_a = 1'b1;
        tick();
        din_a = 1'b0;
        run_len(0, 0, 1'b1, n);
        check("pend_first_high", n, 16);
        repeat (5) tick();
        din_a = 1'b1;
        repeat (3) tick();
        din_a = 1'b0;
        run_len(0, 0, 1'b0, n);
        check("pend_low_remaining", n, 8);
        run_len(0, 0, 1'b1, n);
        check("pend_second_high", n, 16);
        run_len(0, 1, 1'b1, n);
        check("pend_final_holdlow", n, 16);
        check("pend_idle_dout", int'(dout_a), 0);

        // din toggles every 2 cycles: every completed run is exactly one dwell
        prev  = dout_a;
        run   = 0;
        first = 1'b1;
        nruns = 0;
        minr  = 1000;
        maxr  = 0;
        for (int i = 0; i < 200; i++) begin
            din_a = ((i / 2) % 2 == 0);
            tick();
            if (dout_a == prev) begin
                run++;
            end else begin
                if (!first) begin
                    nruns++;
                    if (run < minr) minr = run;
                    if (run > maxr) maxr = run;
                end
                first = 1'b0;
                run   = 1;
                prev  = dout_a;
            end
        end
        check("toggle_min_run", minr, 16);
        check("toggle_max_run", maxr, 16);
        check("toggle_enough_runs", int'(nruns >= 10), 1);
        din_a = 1'b0;
        repeat (80) tick();
        check("toggle_drain_busy", int'(busy_a), 0);
        check("toggle_drain_dout", int'(dout_a), 0);

        // Async reset in the middle of HOLD_HIGH
        din_a = 1'b1;
        tick();
        din_a = 1'b0;
        repeat (5) tick();
        check("rstmid_pre_dout", int'(dout_a), 1);
        rst = 1'b1;
        #1;
        check("rstmid_dout", int'(dout_a), 0);
        check("rstmid_busy", int'(busy_a), 0);
        #2;
        rst = 1'b0;
        tick();
        din_a = 1'b1;
        tick();
        check("rstmid_rise_dout", int'(dout_a), 1);
        din_a = 1'b0;
        run_len(0, 0, 1'b1, n);
        check("rstmid_high_len", n, 16);

        // Watchdog MAX_HIGH=100 with din held high
        din_w = 1'b1;
        tick();
        check("wd_rise", int'(dout_w), 1);
        run_len(1, 0, 1'b1, n);
        check("wd_high_len", n, 100);
        check("wd_fault", int'(fault_w), 1);
        check("wd_fault_busy", int'(busy_w), 0);
        clr_w = 1'b1;
        tick();
        clr_w = 1'b0;
        check("wd_clr_din1_fault", int'(fault_w), 1);
        check("wd_clr_din1_dout", int'(dout_w), 0);
        din_w = 1'b0;
        tick();
        check("wd_noclr_fault", int'(fault_w), 1);
        clr_w = 1'b1;
        tick();
        clr_w = 1'b0;
        check("wd_cleared_fault", int'(fault_w), 0);
        check("wd_cleared_busy", int'(busy_w), 1);
        check("wd_cleared_dout", int'(dout_w), 0);
        run_len(1, 1, 1'b1, n);
        check("wd_holdlow_len", n, 16);

        // MAX_HIGH = MIN_HIGH+1: watchdog trips right after the dwell
        din_s = 1'b1;
        tick();
        run_len(2, 0, 1'b1, n);
        check("tight_high_len", n, 17);
        check("tight_fault", int'(fault_s), 1);
        din_s = 1'b0;
        clr_s = 1'b1;
        tick();
        clr_s = 1'b0;
        check("tight_cleared_fault", int'(fault_s), 0);
        check("tight_cleared_busy", int'(busy_s), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
